// File: rtl/fir_cond_pkg.sv
// Shared constants for the FIR output conditioner: default widths, drop counter
// width, and helpers that derive the rounding constant and saturation limits.
package fir_cond_pkg;

    localparam int IN_W_DEF  = 34;
    localparam int OUT_W_DEF = 16;
    localparam int SHIFT_DEF = 16;
    localparam int DROP_W    = 8;

    // Returned as 64-bit signed; callers size-cast to their own datapath width.
    function automatic longint rnd_const(input int shift);
        return longint'(1) <<< (shift - 1);
    endfunction

    function automatic longint out_max(input int out_w);
        return (longint'(1) <<< (out_w - 1)) - 1;
    endfunction

    function automatic longint out_min(input int out_w);
        return -(longint'(1) <<< (out_w - 1));
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular-buffer FIFO with occupancy count and first-word-fall-through
// head. Head reads as zero while empty so the output is clean out of reset.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    // Storage carries no reset; the empty gate on rd_data hides stale contents.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/fir_out_conditioner.sv
// Decimates the full-precision FIR stream, rounds half-up and saturates to OUT_W,
// then buffers into a FIFO with sticky saturation/overflow status.
module fir_out_conditioner
    import fir_cond_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int SHIFT = SHIFT_DEF,
    parameter int DECIM = 4,
    parameter int DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W-1:0]   in_data,
    input  logic              in_valid,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sat_flag,
    output logic              ovf_flag,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic signed [IN_W:0] RND    = (IN_W+1)'(rnd_const(SHIFT));
    localparam logic signed [IN_W:0] SAT_HI = (IN_W+1)'(out_max(OUT_W));
    localparam logic signed [IN_W:0] SAT_LO = (IN_W+1)'(out_min(OUT_W));
    localparam logic [OUT_W-1:0] MAX_CODE = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MIN_CODE = {1'b1, {(OUT_W-1){1'b0}}};

    logic [PH_W-1:0]      phase;
    logic                 keep;
    logic [2:1]           vld_pipe;
    logic signed [IN_W:0] sum;
    logic signed [IN_W:0] s1_r;
    logic [OUT_W-1:0]     sat_val;
    logic                 sat_hi;
    logic                 sat_lo;
    logic [OUT_W-1:0]     s2_d;
    logic                 s2_sat;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;
    logic                 push;
    logic                 drop;

    assign keep = in_valid && (phase == '0);

    // One guard bit keeps the rounding add from wrapping at the positive extreme.
    assign sum = $signed({in_data[IN_W-1], in_data}) + RND;

    always_comb begin
        sat_hi  = (s1_r > SAT_HI);
        sat_lo  = (s1_r < SAT_LO);
        sat_val = s1_r[OUT_W-1:0];
        if (sat_hi)      sat_val = MAX_CODE;
        else if (sat_lo) sat_val = MIN_CODE;
    end

    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign pop  = out_valid && out_ready;
    assign push = vld_pipe[2] && (!fifo_full || pop);
    assign drop = vld_pipe[2] && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (!rst) begin
            phase    <= '0;
            vld_pipe <= '0;
            s1_r     <= '0;
            s2_d     <= '0;
            s2_sat   <= 1'b0;
            sat_flag <= 1'b0;
            ovf_flag <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (in_valid)
                phase <= (phase == PH_W'(DECIM - 1)) ? '0 : phase + PH_W'(1);
            vld_pipe <= {vld_pipe[1], keep};
            if (keep) s1_r <= sum >>> SHIFT;
            if (vld_pipe[1]) begin
                s2_d   <= sat_val;
                s2_sat <= sat_hi || sat_lo;
            end
            if (vld_pipe[2] && s2_sat) sat_flag <= 1'b1;
            if (drop) begin
                ovf_flag <= 1'b1;
                if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
            end
        end
    end

    sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (s2_d),
        .pop     (pop),
        .rd_data (out_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_valid = !fifo_empty;

endmodule
